nvram_arbiter: RTL and testbench
================================

Name: nvram_arbiter

Overview:
- Shares the Williams2 CMOS high-score/settings RAM (1K x 4) between the game CPU and the HPS ioctl save/load channel.
- Sequences HPS load (download) and save (upload) byte transfers into free RAM cycles. The CPU always has priority and is never stalled.
- Tracks whether the NVRAM is dirty and raises a save request after a quiet period.
- Sits between williams2 and the top-level hps_io on clk_sys (12 MHz).

Parameters:
- AW, 10, NVRAM address width.
- DW, 4, NVRAM data width (at most 8).
- NV_INDEX, 4, ioctl_index value that selects the NVRAM file.
- AUTOSAVE_CYCLES, 12000000, number of quiet clk_sys cycles after the last CPU write before save_req pulses.

Ports:
- clk_sys  in  1  system clock, 12 MHz
- reset  in  1  synchronous, active-high
- cpu_req  in  1  one-cycle strobe per CPU NVRAM access
- cpu_we  in  1  write qualifier for cpu_req
- cpu_addr  in  AW  CPU address
- cpu_din  in  DW  CPU write data
- cpu_dout  out  DW  CPU read data, registered
- ioctl_download  in  1  HPS load active
- ioctl_upload  in  1  HPS save active
- ioctl_index  in  16  file index
- ioctl_wr  in  1  HPS write strobe
- ioctl_rd  in  1  HPS read strobe
- ioctl_addr  in  25  HPS byte address
- ioctl_dout  in  8  HPS write data
- ioctl_din  out  8  HPS read data
- ioctl_wait  out  1  HPS operation pending
- mem_addr  out  AW  RAM address (combinational mux)
- mem_we  out  1  RAM write enable
- mem_din  out  DW  RAM write data
- mem_dout  in  DW  RAM read data; synchronous RAM, 1-cycle latency
- game_hold  out  1  hold the game CPU in reset during load
- nv_dirty  out  1  RAM modified since the last completed load or save
- save_req  out  1  one-cycle autosave request

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pending op dropped; dirty flag and quiet counter cleared. Reset mid-transfer drops the pending op; the HPS side sees ioctl_wait fall.
- An HPS op is accepted only when ioctl_index == NV_INDEX, (ioctl_download & ioctl_wr) or (ioctl_upload & ioctl_rd), and ioctl_addr[24:AW] == 0.
- Out-of-range write: ignored, no wait.
- Out-of-range read: ioctl_din = 8'h00 on the next cycle, no wait.
- FSM states:
  - IDLE: on an accepted write go to PEND_WR, latching addr and ioctl_dout[DW-1:0]. On an accepted read go to PEND_RD, latching addr. ioctl_wait = 1 from the cycle after the strobe.
  - PEND_WR: when cpu_req = 0, drive mem_we = 1 with the latched addr/data, clear ioctl_wait next cycle, return to IDLE. When cpu_req = 1, stay.
  - PEND_RD: when cpu_req = 0, drive mem_addr = latched addr and go to RD_DATA. When cpu_req = 1, stay.
  - RD_DATA: ioctl_din <= {zero-pad, mem_dout}, ioctl_wait <= 0, return to IDLE.
- CPU arbitration:
  - cpu_req is always granted in the same cycle: mem_addr = cpu_addr, mem_we = cpu_we, mem_din = cpu_din.
  - On a CPU read, cpu_dout <= mem_dout exactly one cycle after the grant; otherwise cpu_dout holds.
  - cpu_req coincident with ioctl_wr/rd: CPU wins and the HPS op is latched as pending.
- An HPS strobe arriving while not in IDLE is a protocol violation. It is ignored and the original pending op completes.
- game_hold = ioctl_download & (ioctl_index == NV_INDEX), combinational.
- Dirty tracking:
  - nv_dirty sets on any granted CPU write.
  - nv_dirty clears on the falling edge of an NVRAM-indexed ioctl_download or ioctl_upload.
  - A CPU write in the same cycle as that clear leaves nv_dirty = 1.
- Autosave:
  - The quiet counter resets to 0 on each CPU write and increments while nv_dirty = 1 and no upload is active.
  - At AUTOSAVE_CYCLES-1 it pulses save_req for one cycle, then saturates until the next CPU write. No repeat pulse.
- Latency: HPS write commits 2 cycles after the strobe with no CPU contention. HPS read data is valid 3 cycles after the strobe.

Decomposition:
- Package nvram_pkg holds:
  - the state enum typedef (IDLE, PEND_WR, PEND_RD, RD_DATA);
  - the default NV_INDEX constant;
  - a localparam function for the quiet-counter width, clog2(AUTOSAVE_CYCLES).
- One natural sub-module, nvram_autosave_timer: dirty flag, quiet counter and save_req pulse. The arbiter FSM stays in the top module.

Test Plan:
- Load: NV_INDEX download writing bytes 0x05, 0x0A, 0x1F at addresses 0..2, no CPU traffic -> mem_we pulses with mem_din 5, A, F; game_hold = 1 throughout; ioctl_wait high for 1 cycle per byte.
- Contention: ioctl_wr addr 3, data 0x07 coincident with cpu_req write addr 9, data 0x2, followed by 3 back-to-back cpu_req cycles -> CPU write lands first; HPS write commits in the first cpu_req = 0 cycle; ioctl_wait high until then.
- Save: upload, ioctl_rd addr 1 after RAM[1] = 0xC -> ioctl_din = 0x0C 3 cycles later, ioctl_wait then low.
- Out of range: ioctl_rd addr 0x400 -> ioctl_din = 0x00 next cycle, no wait, no mem access. ioctl_wr addr 0x400 -> no mem_we.
- Autosave (AUTOSAVE_CYCLES = 16): CPU write, then 16 idle cycles -> nv_dirty = 1 and a single save_req pulse. A CPU write at idle cycle 10 restarts the count. Completing an upload clears nv_dirty.
- Reset mid-op: reset asserted in PEND_RD -> next cycle ioctl_wait = 0, FSM in IDLE, nv_dirty = 0, no mem access.

Source files
------------

// File: rtl/nvram_pkg.sv
// Shared types and helpers for the Williams2 CMOS NVRAM arbiter.
// Used by the arbiter top and the autosave timer.
package nvram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PEND_WR,
    PEND_RD,
    RD_DATA
  } state_t;

  localparam logic [15:0] NV_INDEX_DEF = 16'd4;

  function automatic int quiet_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nvram_autosave_timer.sv
// Dirty tracking and quiet-period autosave request for the NVRAM.
// save_req fires once per burst of CPU writes, after a quiet period.
module nvram_autosave_timer
  import nvram_pkg::*;
#(
  parameter int CYCLES = 12000000
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_wr,
  input  logic nv_load,
  input  logic nv_save,
  output logic nv_dirty,
  output logic save_req
);

  localparam int CW = quiet_width(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
  localparam logic [CW-1:0] PRE = CW'(CYCLES - 2);

  logic [CW-1:0] quiet;
  logic load_q;
  logic save_q;
  logic xfer_done;

  assign xfer_done = (load_q & ~nv_load) | (save_q & ~nv_save);

  always_ff @(posedge clk) begin
    if (reset) begin
      quiet    <= '0;
      load_q   <= 1'b0;
      save_q   <= 1'b0;
      nv_dirty <= 1'b0;
      save_req <= 1'b0;
    end else begin
      load_q   <= nv_load;
      save_q   <= nv_save;
      save_req <= 1'b0;
      // A CPU write wins over a coincident end-of-transfer clear
      if (cpu_wr)
        nv_dirty <= 1'b1;
      else if (xfer_done)
        nv_dirty <= 1'b0;
      if (cpu_wr) begin
        quiet <= '0;
      end else if (nv_dirty && !nv_save && quiet != LAST) begin
        quiet    <= quiet + CW'(1);
        save_req <= (quiet == PRE);
      end
    end
  end

endmodule

// File: rtl/nvram_arbiter.sv
// Shares the Williams2 CMOS RAM between the game CPU and HPS ioctl.
// CPU always wins; HPS bytes slot into the first free RAM cycle.
module nvram_arbiter
  import nvram_pkg::*;
#(
  parameter int          AW              = 10,
  parameter int          DW              = 4,
  parameter logic [15:0] NV_INDEX        = NV_INDEX_DEF,
  parameter int          AUTOSAVE_CYCLES = 12000000
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  input  logic          ioctl_download,
  input  logic          ioctl_upload,
  input  logic [15:0]   ioctl_index,
  input  logic          ioctl_wr,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          game_hold,
  output logic          nv_dirty,
  output logic          save_req
);

  state_t state;
  state_t state_nx;

  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_data;
  logic nv_sel;
  logic in_range;
  logic hps_wr;
  logic hps_rd;
  logic cpu_wr;
  logic cpu_rd_q;
  logic unused_ok;

  assign nv_sel    = ioctl_index == NV_INDEX;
  assign in_range  = ioctl_addr[24:AW] == '0;
  assign hps_wr    = nv_sel & ioctl_download & ioctl_wr;
  assign hps_rd    = nv_sel & ioctl_upload & ioctl_rd;
  assign cpu_wr    = cpu_req & cpu_we;
  assign game_hold = ioctl_download & nv_sel;
  assign unused_ok = ^ioctl_dout;

  always_comb begin
    state_nx = state;
    mem_addr = cpu_addr;
    mem_we   = cpu_wr;
    mem_din  = cpu_din;
    unique case (state)
      IDLE: begin
        if (in_range && hps_wr)
          state_nx = PEND_WR;
        else if (in_range && hps_rd)
          state_nx = PEND_RD;
      end
      PEND_WR: begin
        if (!cpu_req) begin
          mem_addr = lat_addr;
          mem_din  = lat_data;
          mem_we   = !reset;
          state_nx = IDLE;
        end
      end
      PEND_RD: begin
        if (!cpu_req) begin
          mem_addr = lat_addr;
          state_nx = RD_DATA;
        end
      end
      RD_DATA: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      lat_addr   <= '0;
      lat_data   <= '0;
      ioctl_wait <= 1'b0;
      ioctl_din  <= '0;
      cpu_dout   <= '0;
      cpu_rd_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      cpu_rd_q <= cpu_req & ~cpu_we;
      if (cpu_rd_q)
        cpu_dout <= mem_dout;
      // Strobes outside IDLE are ignored; the pending op completes
      if (state == IDLE && (hps_wr || hps_rd)) begin
        if (in_range) begin
          lat_addr   <= ioctl_addr[AW-1:0];
          lat_data   <= ioctl_dout[DW-1:0];
          ioctl_wait <= 1'b1;
        end else if (hps_rd && !hps_wr) begin
          ioctl_din <= '0;
        end
      end
      if (state == PEND_WR && !cpu_req)
        ioctl_wait <= 1'b0;
      if (state == RD_DATA) begin
        ioctl_din  <= 8'(mem_dout);
        ioctl_wait <= 1'b0;
      end
    end
  end

  nvram_autosave_timer #(
    .CYCLES(AUTOSAVE_CYCLES)
  ) u_timer (
    .clk      (clk_sys),
    .reset    (reset),
    .cpu_wr   (cpu_wr),
    .nv_load  (game_hold),
    .nv_save  (nv_sel & ioctl_upload),
    .nv_dirty (nv_dirty),
    .save_req (save_req)
  );

endmodule

// File: tb/tb_nvram_arbiter.sv
// Scoreboard bench for nvram_arbiter with a behavioural NVRAM model.
// Directed scenarios followed by randomized CPU/HPS traffic.
module tb_nvram_arbiter;

  localparam logic [15:0] NV = 16'd4;
  localparam int ASC = 16;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [9:0]  cpu_addr;
  logic [3:0]  cpu_din, cpu_dout;
  logic        ioctl_download, ioctl_upload;
  logic [15:0] ioctl_index;
  logic        ioctl_wr, ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_din;
  logic        ioctl_wait;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [3:0]  mem_din;
  logic [3:0]  mem_dout = 4'h0;
  logic        game_hold, nv_dirty, save_req;

  always #5 clk_sys = ~clk_sys;

  nvram_arbiter #(
    .AW(10), .DW(4), .NV_INDEX(NV), .AUTOSAVE_CYCLES(ASC)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout), .game_hold(game_hold),
    .nv_dirty(nv_dirty), .save_req(save_req)
  );

  // synchronous 1K x 4 RAM, read-first
  logic [3:0] ram [1024];
  always @(posedge clk_sys) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model state
  logic [3:0]  mm [1024];
  logic [13:0] wq [$];
  logic [7:0]  rq [$];
  logic [3:0]  cq [$];
  int pk = 0;
  logic [9:0] pa;
  logic [3:0] pd;
  int prdy = 0;
  int idle_at = 0;
  int cyc = 0;

  function automatic bit model_idle();
    return pk == 0 && cyc >= idle_at;
  endfunction

  task automatic step(input bit cr, input bit cw, input logic [9:0] ca,
                      input logic [3:0] cd, input bit hw, input bit hr,
                      input logic [24:0] ha, input logic [7:0] hd);
    bit acc_w, acc_r, idl;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_din = cd;
    ioctl_wr = hw; ioctl_rd = hr; ioctl_addr = ha; ioctl_dout = hd;
    acc_w = hw && ioctl_download && ioctl_index == NV;
    acc_r = hr && ioctl_upload && ioctl_index == NV;
    idl = model_idle();
    if (reset) begin
      pk = 0;
      idle_at = 0;
    end else begin
      // pending HPS op takes the first cycle with no CPU access
      if (pk != 0 && cyc >= prdy && !cr) begin
        if (pk == 1) begin
          mm[pa] = pd;
          wq.push_back({pa, pd});
          idle_at = cyc + 1;
        end else begin
          rq.push_back({4'h0, mm[pa]});
          idle_at = cyc + 2;
        end
        pk = 0;
      end
      if (cr && cw) begin
        mm[ca] = cd;
        wq.push_back({ca, cd});
      end else if (cr) begin
        cq.push_back(mm[ca]);
      end
      if (idl && (acc_w || acc_r)) begin
        if (ha[24:10] != 15'd0) begin
          if (!acc_w) rq.push_back(8'h00);
        end else begin
          pk = acc_w ? 1 : 2;
          pa = ha[9:0];
          pd = hd[3:0];
          prdy = cyc + 1;
        end
      end
    end
    @(posedge clk_sys);
    #1;
    cyc++;
  endtask

  task automatic idle();
    step(0, 0, 10'd0, 4'd0, 0, 0, 25'd0, 8'd0);
  endtask
  task automatic cpu_w(input logic [9:0] a, input logic [3:0] d);
    step(1, 1, a, d, 0, 0, 25'd0, 8'd0);
  endtask
  task automatic cpu_r(input logic [9:0] a);
    step(1, 0, a, 4'd0, 0, 0, 25'd0, 8'd0);
  endtask
  task automatic hps_w(input logic [24:0] a, input logic [7:0] d);
    step(0, 0, 10'd0, 4'd0, 1, 0, a, d);
  endtask
  task automatic hps_r(input logic [24:0] a);
    step(0, 0, 10'd0, 4'd0, 0, 1, a, 8'd0);
  endtask

  // monitor: pops expected responses whenever the DUT presents one
  bit [1:0] rd_sr = '0;
  bit oor_due = 0;
  bit rd_out = 0;
  int rd_age = 0;

  always @(negedge clk_sys) begin
    logic [13:0] ew;
    logic [7:0] er;
    if (mem_we) begin
      if (wq.size() == 0) check("mem_we_unexpected", {mem_addr, mem_din}, 0);
      else begin
        ew = wq.pop_front();
        check("mem_write", {18'd0, mem_addr, mem_din}, {18'd0, ew});
      end
    end
    check("game_hold", game_hold, ioctl_download && ioctl_index == NV);
    if (reset) begin
      rd_sr = '0;
      oor_due = 0;
      rd_out = 0;
    end else begin
      if (rd_sr[1]) begin
        if (cq.size() == 0) check("cpu_rd_unexpected", cpu_dout, 0);
        else check("cpu_dout", cpu_dout, cq.pop_front());
      end
      rd_sr = {rd_sr[0], cpu_req & ~cpu_we};
      if (oor_due) begin
        oor_due = 0;
        er = (rq.size() != 0) ? rq.pop_front() : 8'hxx;
        check("oor_rd_din", ioctl_din, er);
        check("oor_rd_wait", ioctl_wait, 0);
      end
      if (rd_out) begin
        rd_age++;
        if (!ioctl_wait) begin
          rd_out = 0;
          er = (rq.size() != 0) ? rq.pop_front() : 8'hxx;
          check("hps_rd_din", ioctl_din, er);
        end else if (rd_age > 64) begin
          rd_out = 0;
          check("hps_rd_timeout", rd_age, 0);
        end
      end
      if (ioctl_upload && ioctl_rd && !(ioctl_download && ioctl_wr)
          && ioctl_index == NV && !ioctl_wait) begin
        if (ioctl_addr[24:10] != 15'd0) oor_due = 1;
        else begin
          rd_out = 1;
          rd_age = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [24:0] ha;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 4'h0;
      mm[i] = 4'h0;
    end
    reset = 1; ioctl_download = 0; ioctl_upload = 0; ioctl_index = NV;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0;
    ioctl_wr = 0; ioctl_rd = 0; ioctl_addr = 0; ioctl_dout = 0;
    #1;
    idle(); idle();
    check("rst_wait", ioctl_wait, 0);
    check("rst_din", ioctl_din, 0);
    check("rst_cpu_dout", cpu_dout, 0);
    check("rst_dirty", nv_dirty, 0);
    check("rst_save_req", save_req, 0);
    check("rst_mem_we", mem_we, 0);
    reset = 0;
    idle();

    // load three bytes
    ioctl_download = 1;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] b;
      b = (i == 0) ? 8'h05 : (i == 1) ? 8'h0A : 8'h1F;
      hps_w(25'(i), b);
      check("load_wait_hi", ioctl_wait, 1);
      idle();
      check("load_wait_lo", ioctl_wait, 0);
    end
    check("load_hold", game_hold, 1);

    // contention: CPU write and HPS write in the same cycle
    step(1, 1, 10'd9, 4'h2, 1, 0, 25'd3, 8'h07);
    for (int i = 0; i < 3; i++) begin
      check("cont_wait_hi", ioctl_wait, 1);
      cpu_r(10'(i));
    end
    check("cont_wait_still", ioctl_wait, 1);
    idle();
    check("cont_wait_lo", ioctl_wait, 0);
    check("cont_dirty", nv_dirty, 1);
    ioctl_download = 0;
    idle();
    check("load_end_clears_dirty", nv_dirty, 0);

    // save: read back a CPU-written byte
    cpu_w(10'd1, 4'hC);
    ioctl_upload = 1;
    idle();
    hps_r(25'd1);
    check("save_wait_1", ioctl_wait, 1);
    idle();
    check("save_wait_2", ioctl_wait, 1);
    idle();
    check("save_wait_3", ioctl_wait, 0);
    check("save_din_3", ioctl_din, 8'h0C);

    // out of range
    hps_r(25'h400);
    check("oor_din_next", ioctl_din, 8'h00);
    check("oor_no_wait", ioctl_wait, 0);
    ioctl_upload = 0;
    idle();
    check("save_end_clears_dirty", nv_dirty, 0);
    ioctl_download = 1;
    hps_w(25'h400, 8'h03);
    check("oor_wr_no_wait", ioctl_wait, 0);
    idle();
    ioctl_download = 0;
    idle();

    // autosave after a quiet period
    cpu_w(10'd5, 4'h1);
    for (int i = 1; i <= 20; i++) begin
      idle();
      check("as_dirty", nv_dirty, 1);
      check("as_pulse", save_req, i == ASC - 1);
    end
    cpu_w(10'd6, 4'h2);
    for (int i = 1; i < 10; i++) begin
      idle();
      check("as_restart_quiet", save_req, 0);
    end
    cpu_w(10'd6, 4'h3);
    for (int i = 1; i <= 18; i++) begin
      idle();
      check("as_restart_pulse", save_req, i == ASC - 1);
    end
    ioctl_upload = 1;
    idle();
    ioctl_upload = 0;
    idle();
    check("as_upload_clears", nv_dirty, 0);

    // reset while a read is pending
    ioctl_upload = 1;
    cpu_w(10'd7, 4'h3);
    hps_r(25'd2);
    check("rmid_pending", ioctl_wait, 1);
    reset = 1;
    idle();
    reset = 0;
    check("rmid_wait", ioctl_wait, 0);
    check("rmid_dirty", nv_dirty, 0);
    hps_r(25'd2);
    idle(); idle(); idle();
    check("rmid_after_read", ioctl_din, 8'h0F);

    // randomized traffic
    ioctl_download = 1;
    ioctl_upload = 1;
    for (int n = 0; n < 500; n++) begin
      bit cr, cw, hw, hr;
      cr = $urandom_range(0, 99) < 50;
      cw = $urandom_range(0, 1) == 1;
      hw = 0;
      hr = 0;
      ha = 25'($urandom);
      if (model_idle() ? ($urandom_range(0, 99) < 40)
                       : ($urandom_range(0, 99) < 10)) begin
        if ($urandom_range(0, 1) == 1) hw = 1;
        else hr = 1;
        if (model_idle() && $urandom_range(0, 7) == 0)
          ha[24:10] = 15'($urandom_range(1, 32767));
        else
          ha[24:10] = 15'd0;
      end
      step(cr, cw, 10'($urandom), 4'($urandom), hw, hr, ha, 8'($urandom));
    end
    for (int n = 0; n < 20; n++) idle();
    check("drain_writes", wq.size(), 0);
    check("drain_reads", rq.size(), 0);
    check("drain_cpu_reads", cq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
